// File: rtl/dmem_pkg.sv
// Shared types for the data-memory responder.
// Size codes, FSM states and the byte-lane mask helper.
package dmem_pkg;

    typedef enum logic [1:0] {
        SZ_B = 2'b00,
        SZ_H = 2'b01,
        SZ_W = 2'b10,
        SZ_D = 2'b11
    } size_e;

    typedef enum logic [1:0] {
        IDLE = 2'b00,
        BUSY = 2'b01,
        RESP = 2'b10
    } state_e;

    function automatic logic [7:0] byte_mask(
        input logic [1:0] size,
        input logic [2:0] off
    );
        logic [7:0] base;
        case (size)
            SZ_B:    base = 8'h01;
            SZ_H:    base = 8'h03;
            SZ_W:    base = 8'h0f;
            default: base = 8'hff;
        endcase
        return base << off;
    endfunction

endpackage

// File: rtl/dmem_responder_if.sv
// Request/response handshake bundle between the core
// memory stage and the data-memory responder.
interface dmem_responder_if;

    logic        req_valid;
    logic        req_ready;
    logic        req_write;
    logic [63:0] req_addr;
    logic [1:0]  req_size;
    logic        req_unsigned;
    logic [63:0] req_wdata;
    logic        resp_valid;
    logic        resp_ready;
    logic [63:0] resp_rdata;
    logic        resp_err;

    modport master (
        output req_valid, req_write, req_addr, req_size,
        output req_unsigned, req_wdata, resp_ready,
        input  req_ready, resp_valid, resp_rdata, resp_err
    );

    modport slave (
        input  req_valid, req_write, req_addr, req_size,
        input  req_unsigned, req_wdata, resp_ready,
        output req_ready, resp_valid, resp_rdata, resp_err
    );

endinterface

// File: rtl/dmem_lane_align.sv
// Load-path lane aligner: shifts the addressed bytes down,
// then sign- or zero-extends to the full 64 bits.
module dmem_lane_align
    import dmem_pkg::*;
(
    input  logic [63:0] dword,
    input  logic [2:0]  offset,
    input  logic [1:0]  size,
    input  logic        is_unsigned,
    output logic [63:0] result
);

    logic [63:0] sh;
    logic        sx;

    assign sh = dword >> {offset, 3'b000};
    assign sx = ~is_unsigned;

    always_comb begin
        result = sh;
        unique case (size)
            SZ_B: result = {{56{sx & sh[7]}}, sh[7:0]};
            SZ_H: result = {{48{sx & sh[15]}}, sh[15:0]};
            SZ_W: result = {{32{sx & sh[31]}}, sh[31:0]};
            SZ_D: result = sh;
            default: result = sh;
        endcase
    end

endmodule

// File: rtl/dmem_responder.sv
// Multi-cycle data-memory slave with programmable latency,
// sub-word access, extension and misalign/range errors.
module dmem_responder
    import dmem_pkg::*;
#(
    parameter int DEPTH   = 256,
    parameter int LATENCY = 2
) (
    input  logic            clk,
    input  logic            reset,
    dmem_responder_if.slave bus
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = (LATENCY > 1) ? $clog2(LATENCY) : 1;
    localparam logic [CW-1:0] CNT_INIT = CW'(LATENCY - 1);

    state_e        state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic          wr_q, wr_d;
    logic [63:0]   addr_q, addr_d;
    logic [1:0]    size_q, size_d;
    logic          uns_q, uns_d;
    logic [63:0]   wdata_q, wdata_d;
    logic [63:0]   rdata_q, rdata_d;
    logic          err_q, err_d;

    logic [63:0]   mem_q [DEPTH];

    logic          accept;
    logic          access;
    logic          err;
    logic          mem_we;
    logic [2:0]    lsb_mask;
    logic [AW-1:0] idx;
    logic [2:0]    off;
    logic [7:0]    bmask;
    logic [63:0]   wmask;
    logic [63:0]   wshift;
    logic [63:0]   rd_dword;
    logic [63:0]   load_val;

    assign idx      = addr_q[3+AW-1:3];
    assign off      = addr_q[2:0];
    assign lsb_mask = ~(3'b111 << size_q);
    assign err      = ((off & lsb_mask) != 3'b000)
                    | (|addr_q[63:3+AW]);
    assign bmask    = byte_mask(size_q, off);
    assign wshift   = wdata_q << {off, 3'b000};
    assign rd_dword = mem_q[idx];

    always_comb begin
        wmask = '0;
        for (int i = 0; i < 8; i++) begin
            wmask[8*i +: 8] = {8{bmask[i]}};
        end
    end

    dmem_lane_align u_align (
        .dword       (rd_dword),
        .offset      (off),
        .size        (size_q),
        .is_unsigned (uns_q),
        .result      (load_val)
    );

    assign accept = (state_q == IDLE) & bus.req_valid & ~reset;
    assign access = (state_q == BUSY) & (cnt_q == '0);

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE:    if (accept) state_d = BUSY;
            BUSY:    if (access) state_d = RESP;
            RESP:    if (bus.resp_ready) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        bus.req_ready  = (state_q == IDLE) & ~reset;
        bus.resp_valid = (state_q == RESP);
        mem_we         = access & wr_q & ~err & ~reset;
    end

    assign bus.resp_rdata = rdata_q;
    assign bus.resp_err   = err_q;

    always_comb begin
        cnt_d   = cnt_q;
        wr_d    = wr_q;
        addr_d  = addr_q;
        size_d  = size_q;
        uns_d   = uns_q;
        wdata_d = wdata_q;
        rdata_d = rdata_q;
        err_d   = err_q;
        if (accept) begin
            cnt_d   = CNT_INIT;
            wr_d    = bus.req_write;
            addr_d  = bus.req_addr;
            size_d  = bus.req_size;
            uns_d   = bus.req_unsigned;
            wdata_d = bus.req_wdata;
        end else if (access) begin
            err_d   = err;
            rdata_d = (err | wr_q) ? 64'd0 : load_val;
        end else if (state_q == BUSY) begin
            cnt_d = cnt_q - CW'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            cnt_q   <= '0;
            wr_q    <= 1'b0;
            addr_q  <= '0;
            size_q  <= '0;
            uns_q   <= 1'b0;
            wdata_q <= '0;
            rdata_q <= '0;
            err_q   <= 1'b0;
        end else begin
            cnt_q   <= cnt_d;
            wr_q    <= wr_d;
            addr_q  <= addr_d;
            size_q  <= size_d;
            uns_q   <= uns_d;
            wdata_q <= wdata_d;
            rdata_q <= rdata_d;
            err_q   <= err_d;
        end
    end

    // The array keeps its contents across reset.
    always_ff @(posedge clk) begin
        if (mem_we) begin
            mem_q[idx] <= (rd_dword & ~wmask) | (wshift & wmask);
        end
    end

endmodule

// File: tb/tb_dmem_responder.sv
// Bench for dmem_responder: directed scenarios plus random
// traffic against a byte-addressed reference memory.
module tb_dmem_responder;
    import dmem_pkg::*;

    localparam int DEPTH   = 256;
    localparam int LATENCY = 2;
    localparam int NB      = DEPTH * 8;

    logic clk = 1'b0;
    logic reset = 1'b1;
    int   checks = 0;
    int   failures = 0;

    logic [7:0] model [NB];

    dmem_responder_if bus();

    dmem_responder #(.DEPTH(DEPTH), .LATENCY(LATENCY)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    function automatic void ref_access(
        input  logic        wr,
        input  logic [63:0] addr,
        input  logic [1:0]  size,
        input  logic        uns,
        input  logic [63:0] wdata,
        output logic [63:0] rdata,
        output logic        err
    );
        int n;
        n = 1 << size;
        rdata = '0;
        err = ((addr % 64'(n)) != 0) || (addr >= 64'(NB));
        if (err) return;
        if (wr) begin
            for (int i = 0; i < n; i++) model[addr + 64'(i)] = wdata[8*i +: 8];
        end else begin
            for (int i = 0; i < n; i++) rdata[8*i +: 8] = model[addr + 64'(i)];
            if (!uns && n < 8 && rdata[8*n-1])
                for (int i = 8 * n; i < 64; i++) rdata[i] = 1'b1;
        end
    endfunction

    task automatic txn(
        input  logic        wr,
        input  logic [63:0] addr,
        input  logic [1:0]  size,
        input  logic        uns,
        input  logic [63:0] wdata,
        output logic [63:0] rd,
        output logic        er,
        output logic [63:0] exp_rd,
        output logic        exp_er,
        output int          lat,
        output logic        ok
    );
        int t;
        bus.req_write    = wr;
        bus.req_addr     = addr;
        bus.req_size     = size;
        bus.req_unsigned = uns;
        bus.req_wdata    = wdata;
        bus.req_valid    = 1'b1;
        t = 0;
        while (!bus.req_ready && t < 50) begin
            @(posedge clk); #1; t++;
        end
        ok = bus.req_ready;
        @(posedge clk); #1;
        bus.req_valid = 1'b0;
        ref_access(wr, addr, size, uns, wdata, exp_rd, exp_er);
        lat = 0;
        while (!bus.resp_valid && lat < 50) begin
            @(posedge clk); #1; lat++;
        end
        ok = ok & bus.resp_valid;
        rd = bus.resp_rdata;
        er = bus.resp_err;
        @(posedge clk); #1;
    endtask

    task automatic test_reset();
        repeat (3) @(posedge clk);
        #1;
        checks++;
        if (bus.req_ready !== 1'b0 || bus.resp_valid !== 1'b0) begin
            failures++;
            $display("FAIL reset_hs ready=%b valid=%b want 0 0",
                     bus.req_ready, bus.resp_valid);
        end
        checks++;
        if (bus.resp_rdata !== 64'd0 || bus.resp_err !== 1'b0) begin
            failures++;
            $display("FAIL reset_data rdata=%h err=%b want 0 0",
                     bus.resp_rdata, bus.resp_err);
        end
        reset = 1'b0;
        #1;
        checks++;
        if (bus.req_ready !== 1'b1) begin
            failures++;
            $display("FAIL reset_release ready=%b want 1", bus.req_ready);
        end
    endtask

    task automatic test_store_load();
        logic [63:0] rd, xr;
        logic er, xe, ok;
        int lat;
        txn(1, 64'h10, SZ_D, 0, 64'h1122334455667788, rd, er, xr, xe, lat, ok);
        checks++;
        if (!ok || er !== 1'b0 || rd !== 64'd0 || lat != LATENCY) begin
            failures++;
            $display("FAIL sd_0x10 ok=%b err=%b rdata=%h lat=%0d want 1 0 0 %0d",
                     ok, er, rd, lat, LATENCY);
        end
        txn(0, 64'h10, SZ_D, 0, 0, rd, er, xr, xe, lat, ok);
        checks++;
        if (!ok || er !== 1'b0 || rd !== 64'h1122334455667788 || lat != LATENCY) begin
            failures++;
            $display("FAIL ld_0x10 ok=%b err=%b rdata=%h lat=%0d want 1 0 1122334455667788 %0d",
                     ok, er, rd, lat, LATENCY);
        end
    endtask

    task automatic test_subword();
        logic [63:0] rd, xr;
        logic er, xe, ok;
        int lat;
        txn(0, 64'h17, SZ_B, 0, 0, rd, er, xr, xe, lat, ok);
        checks++;
        if (!ok || er !== 1'b0 || rd !== 64'h11) begin
            failures++;
            $display("FAIL lb_0x17 rdata=%h err=%b want 11 0", rd, er);
        end
        txn(1, 64'h10, SZ_B, 0, 64'hFF, rd, er, xr, xe, lat, ok);
        txn(0, 64'h10, SZ_B, 0, 0, rd, er, xr, xe, lat, ok);
        checks++;
        if (!ok || er !== 1'b0 || rd !== 64'hFFFFFFFFFFFFFFFF) begin
            failures++;
            $display("FAIL lb_0x10 rdata=%h err=%b want ffffffffffffffff 0", rd, er);
        end
        txn(0, 64'h10, SZ_B, 1, 0, rd, er, xr, xe, lat, ok);
        checks++;
        if (!ok || er !== 1'b0 || rd !== 64'hFF) begin
            failures++;
            $display("FAIL lbu_0x10 rdata=%h err=%b want ff 0", rd, er);
        end
        txn(0, 64'h10, SZ_D, 0, 0, rd, er, xr, xe, lat, ok);
        checks++;
        if (!ok || er !== 1'b0 || rd !== 64'h11223344556677FF) begin
            failures++;
            $display("FAIL ld_after_sb rdata=%h want 11223344556677ff", rd);
        end
    endtask

    task automatic test_misaligned();
        logic [63:0] rd, xr;
        logic er, xe, ok;
        int lat;
        txn(0, 64'h12, SZ_W, 0, 0, rd, er, xr, xe, lat, ok);
        checks++;
        if (!ok || er !== 1'b1 || rd !== 64'd0) begin
            failures++;
            $display("FAIL lw_0x12 err=%b rdata=%h want 1 0", er, rd);
        end
        txn(1, 64'h13, SZ_H, 0, 64'hABCD, rd, er, xr, xe, lat, ok);
        checks++;
        if (!ok || er !== 1'b1 || rd !== 64'd0) begin
            failures++;
            $display("FAIL sh_0x13 err=%b rdata=%h want 1 0", er, rd);
        end
        txn(0, 64'h10, SZ_D, 0, 0, rd, er, xr, xe, lat, ok);
        checks++;
        if (!ok || er !== 1'b0 || rd !== 64'h11223344556677FF) begin
            failures++;
            $display("FAIL ld_after_misalign rdata=%h want 11223344556677ff", rd);
        end
    endtask

    task automatic test_out_of_range();
        logic [63:0] rd, xr;
        logic er, xe, ok;
        int lat;
        txn(0, 64'h800, SZ_D, 0, 0, rd, er, xr, xe, lat, ok);
        checks++;
        if (!ok || er !== 1'b1 || rd !== 64'd0) begin
            failures++;
            $display("FAIL ld_0x800 err=%b rdata=%h want 1 0", er, rd);
        end
    endtask

    task automatic test_backpressure();
        logic [63:0] exp_rd, rd, xr;
        logic exp_er, er, xe, ok;
        int t, lat, extra;
        ref_access(0, 64'h10, SZ_D, 0, 0, exp_rd, exp_er);
        bus.req_write = 0;
        bus.req_addr  = 64'h10;
        bus.req_size  = SZ_D;
        bus.req_valid = 1;
        bus.resp_ready = 0;
        @(posedge clk); #1;
        bus.req_valid = 0;
        t = 0;
        while (!bus.resp_valid && t < 50) begin
            @(posedge clk); #1; t++;
        end
        checks++;
        if (bus.resp_valid !== 1'b1) begin
            failures++;
            $display("FAIL bp_resp timeout valid=%b want 1", bus.resp_valid);
        end
        for (int c = 0; c < 5; c++) begin
            if (c == 1) begin
                bus.req_write = 1;
                bus.req_wdata = 64'hDEADBEEFDEADBEEF;
                bus.req_valid = 1;
            end
            checks++;
            if (bus.resp_valid !== 1'b1 || bus.resp_rdata !== exp_rd ||
                bus.req_ready !== 1'b0) begin
                failures++;
                $display("FAIL bp_hold c=%0d valid=%b rdata=%h ready=%b want 1 %h 0",
                         c, bus.resp_valid, bus.resp_rdata, bus.req_ready, exp_rd);
            end
            @(posedge clk); #1;
            bus.req_valid = 0;
        end
        bus.req_write = 0;
        bus.resp_ready = 1;
        @(posedge clk); #1;
        extra = 0;
        for (int c = 0; c < 8; c++) begin
            if (bus.resp_valid) extra++;
            @(posedge clk); #1;
        end
        checks++;
        if (extra != 0) begin
            failures++;
            $display("FAIL bp_single_resp extra_cycles=%0d want 0", extra);
        end
        txn(0, 64'h10, SZ_D, 0, 0, rd, er, xr, xe, lat, ok);
        checks++;
        if (!ok || rd !== xr || er !== xe) begin
            failures++;
            $display("FAIL bp_after rdata=%h err=%b want %h %b", rd, er, xr, xe);
        end
    endtask

    task automatic test_reset_mid();
        logic [63:0] rd, xr;
        logic er, xe, ok;
        int lat;
        txn(1, 64'h20, SZ_D, 0, 64'h5, rd, er, xr, xe, lat, ok);
        bus.req_write = 1;
        bus.req_addr  = 64'h20;
        bus.req_size  = SZ_D;
        bus.req_wdata = 64'hA;
        bus.req_valid = 1;
        @(posedge clk); #1;
        bus.req_valid = 0;
        reset = 1;
        @(posedge clk); #1;
        reset = 0;
        #1;
        checks++;
        if (bus.resp_valid !== 1'b0 || bus.req_ready !== 1'b1) begin
            failures++;
            $display("FAIL reset_mid valid=%b ready=%b want 0 1",
                     bus.resp_valid, bus.req_ready);
        end
        @(posedge clk); #1;
        txn(0, 64'h20, SZ_D, 0, 0, rd, er, xr, xe, lat, ok);
        checks++;
        if (!ok || er !== 1'b0 || rd !== 64'h5) begin
            failures++;
            $display("FAIL ld_0x20_after_reset rdata=%h err=%b want 5 0", rd, er);
        end
    endtask

    task automatic test_back_to_back();
        int acc[$];
        int waited;
        logic [63:0] xr;
        logic xe;
        bus.req_write = 0;
        bus.req_addr  = 64'h10;
        bus.req_size  = SZ_D;
        bus.req_valid = 1;
        bus.resp_ready = 1;
        for (int c = 0; c < 20; c++) begin
            if (bus.req_ready) begin
                acc.push_back(c);
                ref_access(0, 64'h10, SZ_D, 0, 0, xr, xe);
            end
            if (c == 19) bus.req_valid = 0;
            @(posedge clk); #1;
        end
        waited = 0;
        while (!bus.req_ready && waited < 50) begin
            @(posedge clk); #1; waited++;
        end
        checks++;
        if (acc.size() < 4 || !bus.req_ready) begin
            failures++;
            $display("FAIL b2b_count accepts=%0d ready=%b want >=4 1",
                     acc.size(), bus.req_ready);
        end
        for (int i = 1; i < acc.size(); i++) begin
            checks++;
            if (acc[i] - acc[i-1] != LATENCY + 2) begin
                failures++;
                $display("FAIL b2b_gap i=%0d gap=%0d want %0d",
                         i, acc[i] - acc[i-1], LATENCY + 2);
            end
        end
    endtask

    task automatic test_random();
        logic [63:0] rd, xr, a, wd;
        logic er, xe, ok, wr, un;
        logic [1:0] sz;
        int lat, bad, n, sel;
        bad = 0;
        for (int i = 0; i < DEPTH; i++) begin
            wd = {$urandom, $urandom};
            txn(1, 64'(i * 8), SZ_D, 0, wd, rd, er, xr, xe, lat, ok);
            if (!ok || er !== 1'b0) bad++;
        end
        checks++;
        if (bad != 0) begin
            failures++;
            $display("FAIL rand_fill bad=%0d want 0", bad);
        end
        for (int k = 0; k < 200; k++) begin
            wr  = 1'($urandom_range(0, 1));
            un  = 1'($urandom_range(0, 1));
            sz  = 2'($urandom_range(0, 3));
            wd  = {$urandom, $urandom};
            n   = 1 << sz;
            sel = $urandom_range(0, 15);
            a   = 64'($urandom_range(0, NB - 1));
            if (sel == 0) a = 64'(NB) + 64'($urandom_range(0, 4095));
            else if (sel > 2) a = a & ~64'(n - 1);
            txn(wr, a, sz, un, wd, rd, er, xr, xe, lat, ok);
            checks++;
            if (!ok || rd !== xr || er !== xe || lat != LATENCY) begin
                failures++;
                $display("FAIL rand k=%0d wr=%b a=%h sz=%0d u=%b rdata=%h err=%b lat=%0d want %h %b %0d",
                         k, wr, a, sz, un, rd, er, lat, xr, xe, LATENCY);
            end
        end
    endtask

    initial begin
        bus.req_valid    = 0;
        bus.req_write    = 0;
        bus.req_addr     = '0;
        bus.req_size     = '0;
        bus.req_unsigned = 0;
        bus.req_wdata    = '0;
        bus.resp_ready   = 1;
        test_reset();
        test_store_load();
        test_subword();
        test_misaligned();
        test_out_of_range();
        test_backpressure();
        test_reset_mid();
        test_back_to_back();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/dmem_responder.md
# dmem_responder

Data-memory responder serving load/store requests from the 64-bit core over a valid/ready request and response handshake. It replaces the single-cycle data memory array with a multi-cycle slave that has programmable latency. It supports byte, half, word and doubleword accesses, with sign or zero extension on loads and an error response for misaligned or out-of-range accesses. It sits between the core's memory stage and the doubleword storage array.

## Interface
- `DEPTH`, 256: number of 64-bit doublewords in the array; must be a power of two.
- `LATENCY`, 2: access latency in clock edges (≥1), measured from the accepting edge to the edge that raises `resp_valid`.
- `clk` in 1: single clock; all state updates on the rising edge.
- `reset` in 1: synchronous, active-high.
- `req_valid` in 1: request present.
- `req_ready` out 1: responder can accept a request.
- `req_write` in 1: 1 = store, 0 = load.
- `req_addr` in 64: byte address.
- `req_size` in 2: 00 byte, 01 half, 10 word, 11 doubleword.
- `req_unsigned` in 1: loads only; 1 = zero-extend, 0 = sign-extend. Ignored for doubleword loads.
- `req_wdata` in 64: store data, right-justified (bits [8·n−1:0] significant).
- `resp_valid` out 1: response present.
- `resp_ready` in 1: core accepts the response.
- `resp_rdata` out 64: load result, aligned and extended; 0 for stores and errors.
- `resp_err` out 1: access was misaligned or out of range.

## Operation
- FSM states:
  - IDLE: `req_ready`=1.
  - BUSY: latency countdown.
  - RESP: `resp_valid`=1.
- IDLE→BUSY on `req_valid & req_ready`. At that edge:
  - Latch write, addr, size, unsigned and wdata.
  - Load the counter with `LATENCY`−1.
- BUSY: if counter==0, perform the access at that edge and go to RESP; otherwise decrement.
- RESP→IDLE on `resp_valid & resp_ready`. `resp_rdata` and `resp_err` hold until then.
- Error check, applied at the access edge:
  - Misaligned: `addr` mod 2^size ≠ 0.
  - Out of range: `addr` ≥ `DEPTH`·8.
  - On error: no array write, `resp_rdata`=0, `resp_err`=1.
- Array indexing: index = `addr[3+log2(DEPTH)−1:3]`; lane offset = `addr[2:0]`.
- Store:
  - Writes only the bytes selected by size and offset.
  - `req_wdata` is shifted left by 8·offset.
  - Other bytes of the doubleword are preserved.
- Load:
  - Reads the doubleword and shifts right by 8·offset.
  - Masks to the access size, then sign- or zero-extends to 64 bits.
- Store response: `resp_rdata`=0, `resp_err`=0 on success.
- Reset:
  - Returns to IDLE and clears the counter.
  - Drives `resp_valid`=0, `resp_rdata`=0, `resp_err`=0.
  - Does not clear the array.
- Reset while in BUSY: the pending access is dropped and a store not yet at its access edge never commits.
- While `reset`=1, `req_ready`=0.
- `req_valid` in BUSY or RESP is ignored and is not queued.

## Timing
- `req_ready` is a combinational decode of state==IDLE gated by `!reset`. `resp_valid` is a registered state decode.
- For acceptance at edge E0:
  - Array access happens at edge E0+`LATENCY`.
  - `resp_valid` is high from E0+`LATENCY` onward.
- Response accepted at edge Er: `req_ready`=1 in the cycle after Er.
- Back-to-back throughput: one transaction per `LATENCY`+2 cycles when `resp_ready` is held at 1.
- Backpressure: `resp_ready`=0 holds RESP indefinitely with outputs stable.
- Request and response handshakes are never simultaneous, because they occur in different states.

## Structure
- Shared package `dmem_pkg`:
  - Size encodings `SZ_B/SZ_H/SZ_W/SZ_D`.
  - State enum `IDLE/BUSY/RESP`.
  - Function computing the byte mask from size and offset.
- Sub-module `dmem_lane_align` (combinational): takes the read doubleword, offset, size and unsigned flag, and produces the extended load result.
- The array and FSM live in the top module. Expected RTL size is ~200 lines.

## Test plan
- Store then load: reset, sd 0x1122334455667788 @0x10, ld @0x10.
  - Required: rdata 0x1122334455667788, err 0.
  - Required: `resp_valid` rises exactly 2 edges after each accepting edge.
- Sub-word loads and stores on the same doubleword:
  - lb @0x17 → 0x0000000000000011.
  - sb 0xFF @0x10, then lb @0x10 → 0xFFFFFFFFFFFFFFFF and lbu @0x10 → 0x00000000000000FF.
  - ld @0x10 → 0x11223344556677FF.
- Misaligned accesses:
  - lw @0x12 → err 1, rdata 0.
  - sh @0x13 → err 1.
  - A following ld @0x10 shows the doubleword unchanged.
- Out of range: ld @0x800 with DEPTH=256 → err 1, rdata 0.
- Backpressure: hold `resp_ready`=0 for 5 cycles after `resp_valid`.
  - Required: `resp_valid`/`resp_rdata` stable and `req_ready`=0.
  - Required: a pulsed `req_valid` is ignored, with exactly one response observed.
- Reset mid-operation:
  - Setup: sd 0x5 @0x20 completes, then a second sd 0xA @0x20 is accepted.
  - Stimulus: assert `reset` in the first BUSY cycle.
  - Required after reset: `resp_valid`=0, `req_ready`=1.
  - Required: ld @0x20 → 0x5.
